// File: rtl/dual_bridge.sv
// Bridges a clk-domain valid/ready request/response pair onto a transition-signalled
// dual-rail bus port; rail pair for bit i is {t = [2i+1], f = [2i]}.
`ifndef SIZE
`define SIZE 4
`endif

module dual_bridge #(
  parameter int INPUT   = `SIZE,
  parameter int OUTPUT  = `SIZE,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [INPUT-1:0]    req_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [OUTPUT-1:0]   rsp_data,
  output logic                rsp_err,
  output logic [2*INPUT-1:0]  bus_req,
  input  logic [2*OUTPUT-1:0] bus_rsp
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {SYNC, IDLE, WAIT, RESP} state_t;

  state_t state, state_nxt;

  logic [2*OUTPUT-1:0] sync1, sync2, rsp_hist;
  logic [2*OUTPUT-1:0] rsp_prev, rsp_prev_nxt;
  logic [2*INPUT-1:0]  req_prev, bus_req_nxt;
  logic [CW-1:0]       count, count_nxt;
  logic [OUTPUT-1:0]   data_nxt, toggled_t;
  logic                err_nxt;
  logic                complete;

  // Synchronizer plus one history stage for the two-cycle stability check.
  always_ff @(posedge clk) begin
    sync1    <= bus_rsp;
    sync2    <= sync1;
    rsp_hist <= sync2;
  end

  // A bit is complete only when exactly one of its rails moved; none or both block completion.
  always_comb begin
    complete  = (sync2 == rsp_hist);
    toggled_t = '0;
    for (int i = 0; i < OUTPUT; i++) begin
      toggled_t[i] = sync2[2*i+1] ^ rsp_prev[2*i+1];
      if ((sync2[2*i+1] ^ rsp_prev[2*i+1]) == (sync2[2*i] ^ rsp_prev[2*i]))
        complete = 1'b0;
    end
  end

  always_comb begin
    state_nxt    = state;
    rsp_prev_nxt = rsp_prev;
    bus_req_nxt  = req_prev;
    count_nxt    = count;
    data_nxt     = rsp_data;
    err_nxt      = rsp_err;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    case (state)
      SYNC: begin
        rsp_prev_nxt = sync2;
        state_nxt    = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
        if (complete) rsp_prev_nxt = sync2;
        if (req_valid) begin
          for (int i = 0; i < INPUT; i++) begin
            bus_req_nxt[2*i+1] = req_prev[2*i+1] ^ req_data[i];
            bus_req_nxt[2*i]   = req_prev[2*i] ^ ~req_data[i];
          end
          count_nxt = '0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        count_nxt = count + 1'b1;
        if (complete) begin
          data_nxt     = toggled_t;
          err_nxt      = 1'b0;
          rsp_prev_nxt = sync2;
          state_nxt    = RESP;
        end else if (count == CW'(TIMEOUT - 1)) begin
          // Snapshot is left alone so a late reply is still recognised and absorbed.
          data_nxt  = '0;
          err_nxt   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (complete) rsp_prev_nxt = sync2;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= SYNC;
      rsp_prev <= '0;
      req_prev <= '0;
      bus_req  <= '0;
      count    <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rsp_prev <= rsp_prev_nxt;
      req_prev <= bus_req_nxt;
      bus_req  <= bus_req_nxt;
      count    <= count_nxt;
      rsp_data <= data_nxt;
      rsp_err  <= err_nxt;
    end
  end

endmodule
